// File: rtl/legv8_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : legv8_host_pkg
//  Description : Shared types and constants for the LEGv8 host data-memory
//                port: session state encoding, halt instruction, word size
//                and the word-index to byte-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package legv8_host_pkg;

  // Encoding of B #0, the instruction that marks the end of a program run
  localparam logic [31:0] HALT_INST_B0 = 32'h1400_0000;

  // Data-memory word size in bytes and the matching index shift
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  // Session state
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_HALT_WAIT = 3'd3,
    ST_DUMP      = 3'd4,
    ST_DONE      = 3'd5
  } host_state_e;

  // Byte address of word idx; the add wraps modulo 2^64 by construction
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input logic [31:0] idx);
    return base + ({32'd0, idx} << WORD_SHIFT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_host_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_host_port_if
//  Description : Load stream, dump stream and data-memory port bundle of
//                the host data-memory port. The slave modport is the port
//                block itself; the master modport is the host/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_host_port_if;

  // Load stream (host -> port)
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;

  // Dump stream (port -> host)
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  // Data-memory port
  logic        mem_sel;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  s_valid, s_data, m_ready, mem_rdata,
    output s_ready, m_valid, m_data, m_last,
           mem_sel, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data, m_ready, mem_rdata,
    input  s_ready, m_valid, m_data, m_last,
           mem_sel, mem_we, mem_re, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_rd_buf.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rd_buf
//  Description : Single-entry read capture/hold for the dump stream. The
//                word is presented in the cycle the memory returns it and is
//                held in a register until the consumer accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_rd_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue,   // memory read strobe this cycle
  input  logic        rd_last,    // the word being read is the final one
  input  logic [63:0] rd_data,    // memory read data, valid one cycle after rd_issue
  input  logic        m_ready,
  output logic        m_valid,
  output logic [63:0] m_data,
  output logic        m_last
);

  logic        pend_q, pend_d;   // read data arrives this cycle
  logic        held_q, held_d;   // word parked in data_q awaiting accept
  logic [63:0] data_q, data_d;
  logic        last_q, last_d;

  assign m_valid = pend_q | held_q;
  assign m_data  = held_q ? data_q : (pend_q ? rd_data : 64'd0);
  assign m_last  = last_q;

  // Park an unaccepted word, release on accept, track last flag per word
  always_comb begin
    pend_d = rd_issue;
    held_d = held_q;
    data_d = data_q;
    last_d = last_q;
    if (pend_q && !m_ready) begin
      held_d = 1'b1;
      data_d = rd_data;
    end
    if (held_q && m_ready) begin
      held_d = 1'b0;
    end
    if (m_valid && m_ready) begin
      last_d = 1'b0;
    end
    if (rd_issue) begin
      last_d = rd_last;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      held_q <= 1'b0;
      data_q <= 64'd0;
      last_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      held_q <= held_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_host_port.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_host_port
//  Description : Host-side data-memory port for the LEGv8 pipeline. Holds
//                the CPU in reset while the host preloads data memory,
//                releases it, watches WB for the halt instruction, then
//                re-freezes the CPU and streams a memory region back out.
//                Optional RUN watchdog: DMEM_HOST_PORT_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_host_port
  import legv8_host_pkg::*;
#(
  parameter logic [31:0] HALT_INST      = HALT_INST_B0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [63:0]     base_addr,
  input  logic [31:0]     load_cnt,
  input  logic [31:0]     dump_cnt,
  dmem_host_port_if.slave bus,
  output logic            cpu_rst,
  input  logic [31:0]     wb_inst,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  host_state_e state_q, state_d;
  logic [63:0] base_q, base_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] dump_cnt_q, dump_cnt_d;
  logic [31:0] idx_q, idx_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        mem_sel_q, mem_sel_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;

  logic        load_open;
  logic        load_hs;
  logic        dump_hs;
  logic        rd_last;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last_o;

`ifdef DMEM_HOST_PORT_WDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
`endif

  // LOAD accepts words only until the count is reached; the final write
  // cycle is then spent in LOAD with s_ready low before the CPU is released
  assign load_open = (state_q == ST_LOAD) && (idx_q != load_cnt_q);
  assign load_hs   = load_open && bus.s_valid;
  assign dump_hs   = (state_q == ST_DUMP) && rd_valid && bus.m_ready;
  assign rd_last   = (idx_q == dump_cnt_q - 32'd1);

  // Next-state, counter and memory-strobe computation
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    load_cnt_d  = load_cnt_q;
    dump_cnt_d  = dump_cnt_q;
    idx_d       = idx_q;
    cpu_rst_d   = cpu_rst_q;
    mem_sel_d   = mem_sel_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef DMEM_HOST_PORT_WDOG_EN
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        cpu_rst_d = 1'b1;
        mem_sel_d = 1'b1;
        if (start) begin
          base_d     = base_addr;
          load_cnt_d = load_cnt;
          dump_cnt_d = dump_cnt;
          idx_d      = 32'd0;
`ifdef DMEM_HOST_PORT_WDOG_EN
          wdog_d     = 32'd0;
          timeout_d  = 1'b0;
`endif
          if (load_cnt == 32'd0) begin
            state_d   = ST_RUN;
            cpu_rst_d = 1'b0;
            mem_sel_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr(base_q, idx_q);
          mem_wdata_d = bus.s_data;
          idx_d       = idx_q + 32'd1;
        end else if (idx_q == load_cnt_q) begin
          state_d   = ST_RUN;
          cpu_rst_d = 1'b0;
          mem_sel_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (wb_inst == HALT_INST) begin
          state_d = ST_HALT_WAIT;
        end
`ifdef DMEM_HOST_PORT_WDOG_EN
        else if (wdog_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d   = ST_HALT_WAIT;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
`endif
      end
      ST_HALT_WAIT: begin
        cpu_rst_d = 1'b1;
        mem_sel_d = 1'b1;
        idx_d     = 32'd0;
        if (dump_cnt_q == 32'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_DUMP;
          mem_re_d   = 1'b1;
          mem_addr_d = word_addr(base_q, 32'd0);
        end
      end
      ST_DUMP: begin
        if (dump_hs) begin
          if (rd_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = idx_q + 32'd1;
            mem_re_d   = 1'b1;
            mem_addr_d = word_addr(base_q, idx_q + 32'd1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cpu_rst_d = 1'b1;
        mem_sel_d = 1'b1;
      end
    endcase
  end

  // Session state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= 64'd0;
      load_cnt_q  <= 32'd0;
      dump_cnt_q  <= 32'd0;
      idx_q       <= 32'd0;
      cpu_rst_q   <= 1'b1;
      mem_sel_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      load_cnt_q  <= load_cnt_d;
      dump_cnt_q  <= dump_cnt_d;
      idx_q       <= idx_d;
      cpu_rst_q   <= cpu_rst_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef DMEM_HOST_PORT_WDOG_EN
  // RUN watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  dmem_rd_buf u_rd_buf (
    .clk      (clk),
    .rst      (rst),
    .rd_issue (mem_re_q),
    .rd_last  (rd_last),
    .rd_data  (bus.mem_rdata),
    .m_ready  (bus.m_ready),
    .m_valid  (rd_valid),
    .m_data   (rd_data),
    .m_last   (rd_last_o)
  );

  assign bus.s_ready   = load_open;
  assign bus.m_valid   = rd_valid;
  assign bus.m_data    = rd_data;
  assign bus.m_last    = rd_last_o;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_host_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_host_port
//  Description : Scoreboard bench for dmem_host_port: expected memory writes
//                and dump words are queued by the stimulus, a negedge monitor
//                pops and compares them, plus directed timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_host_port;

`ifdef DMEM_HOST_PORT_WDOG_EN
  localparam logic [31:0] C_TIMEOUT = 32'd100;
`else
  localparam logic [31:0] C_TIMEOUT = 32'd10_000_000;
`endif
  localparam logic [31:0] C_HALT = 32'h1400_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] base_addr;
  logic [31:0] load_cnt;
  logic [31:0] dump_cnt;
  logic        cpu_rst;
  logic [31:0] wb_inst;
  logic        busy;
  logic        done;
  logic        timeout;

  dmem_host_port_if bus_if ();

  dmem_host_port #(
    .HALT_INST      (C_HALT),
    .TIMEOUT_CYCLES (C_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .load_cnt  (load_cnt),
    .dump_cnt  (dump_cnt),
    .bus       (bus_if),
    .cpu_rst   (cpu_rst),
    .wb_inst   (wb_inst),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic [63:0] d; logic l; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  int n_vec = 0;
  int n_err = 0;
  int n_re  = 0;
  int re0;

  // Data memory model: synchronous read, one cycle latency
  logic [63:0] mem_model [logic [63:0]];
  always @(posedge clk) begin
    if (bus_if.mem_re)
      bus_if.mem_rdata <= mem_model.exists(bus_if.mem_addr) ? mem_model[bus_if.mem_addr] : 64'd0;
    if (bus_if.mem_sel && bus_if.mem_we)
      mem_model[bus_if.mem_addr] = bus_if.mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare writes and dump handshakes against the queues
  always @(negedge clk) begin
    if (!rst && bus_if.mem_re) n_re++;
    if (!rst && bus_if.mem_we) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_unexp: got write at %h, expected none", bus_if.mem_addr);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", bus_if.mem_addr, w.a);
        check("wr_data", bus_if.mem_wdata, w.d);
        check("wr_sel", {63'd0, bus_if.mem_sel}, 64'd1);
      end
    end
    if (!rst && bus_if.m_valid && bus_if.m_ready) begin
      if (exp_rd.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_unexp: got dump word %h, expected none", bus_if.m_data);
      end else begin
        rd_t r;
        r = exp_rd.pop_front();
        check("rd_data", bus_if.m_data, r.d);
        check("rd_last", {63'd0, bus_if.m_last}, {63'd0, r.l});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [63:0] b, input logic [31:0] lc, input logic [31:0] dc);
    base_addr = b; load_cnt = lc; dump_cnt = dc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d);
    int n;
    n = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    while (!bus_if.s_ready && n < 20) begin tick(); n++; end
    check("s_ready", {63'd0, bus_if.s_ready}, 64'd1);
    tick();
    bus_if.s_valid = 1'b0;
  endtask

  task automatic halt();
    wb_inst = C_HALT;
    tick();
    wb_inst = 32'd0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300 && !done; n++) tick();
    check("done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 64'd0; load_cnt = 32'd0; dump_cnt = 32'd0;
    wb_inst = 32'd0;
    bus_if.s_valid = 1'b0; bus_if.s_data = 64'd0; bus_if.m_ready = 1'b0;
    bus_if.mem_rdata = 64'd0;
    tick(); tick();
    // Reset state
    check("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("rst_mem_sel", {63'd0, bus_if.mem_sel}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_m_valid", {63'd0, bus_if.m_valid}, 64'd0);
    check("rst_s_ready", {63'd0, bus_if.s_ready}, 64'd0);
    check("rst_mem_we", {63'd0, bus_if.mem_we}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    rst = 1'b0;
    tick();

    // Preload then dump round trip
    exp_wr.push_back('{64'h18, 64'd9});
    exp_wr.push_back('{64'h20, 64'd2});
    exp_wr.push_back('{64'h28, 64'h45});
    exp_wr.push_back('{64'h30, 64'd1});
    exp_rd.push_back('{64'd9, 1'b0});
    exp_rd.push_back('{64'd2, 1'b0});
    exp_rd.push_back('{64'h45, 1'b0});
    exp_rd.push_back('{64'd1, 1'b1});
    bus_if.m_ready = 1'b1;
    begin_session(64'h18, 32'd4, 32'd4);
    check("load_busy", {63'd0, busy}, 64'd1);
    send_word(64'd9);
    send_word(64'd2);
    send_word(64'h45);
    send_word(64'd1);
    check("lastwr_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("lastwr_we", {63'd0, bus_if.mem_we}, 64'd1);
    tick();
    check("run_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    check("run_mem_sel", {63'd0, bus_if.mem_sel}, 64'd0);
    tick(); tick();
    re0 = n_re;
    halt();
    check("hw_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    check("hw_mem_re", {63'd0, bus_if.mem_re}, 64'd0);
    tick();
    check("d0_mem_re", {63'd0, bus_if.mem_re}, 64'd1);
    check("d0_addr", bus_if.mem_addr, 64'h18);
    check("d0_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("d0_m_valid", {63'd0, bus_if.m_valid}, 64'd0);
    tick();
    check("d1_m_valid", {63'd0, bus_if.m_valid}, 64'd1);
    repeat (7) tick();
    check("rt_done", {63'd0, done}, 64'd1);
    check("rt_busy", {63'd0, busy}, 64'd0);
    check("rt_re_cnt", n_re - re0, 64'd4);

    // Zero counts
    re0 = n_re;
    begin_session(64'h18, 32'd0, 32'd0);
    check("z_cpu_rst", {63'd0, cpu_rst}, 64'd0);
    check("z_s_ready", {63'd0, bus_if.s_ready}, 64'd0);
    check("z_busy", {63'd0, busy}, 64'd1);
    halt();
    check("z_hw_busy", {63'd0, busy}, 64'd1);
    tick();
    check("z_done", {63'd0, done}, 64'd1);
    check("z_m_valid", {63'd0, bus_if.m_valid}, 64'd0);
    check("z_re_cnt", n_re - re0, 64'd0);

    // Back-pressure on word 1
    exp_rd.push_back('{64'd9, 1'b0});
    exp_rd.push_back('{64'd2, 1'b0});
    exp_rd.push_back('{64'h45, 1'b1});
    re0 = n_re;
    begin_session(64'h18, 32'd0, 32'd3);
    halt();
    tick(); tick(); tick();
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {63'd0, bus_if.m_valid}, 64'd1);
      check("bp_data", bus_if.m_data, 64'd2);
      check("bp_last", {63'd0, bus_if.m_last}, 64'd0);
    end
    tick();
    check("bp_re_cnt", n_re - re0, 64'd2);
    bus_if.m_ready = 1'b1;
    wait_done();
    check("bp_re_total", n_re - re0, 64'd3);

    // Reset mid-DUMP
    bus_if.m_ready = 1'b0;
    begin_session(64'h18, 32'd0, 32'd4);
    halt();
    tick(); tick();
    check("rd_pre_valid", {63'd0, bus_if.m_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    check("rm_mem_sel", {63'd0, bus_if.mem_sel}, 64'd1);
    check("rm_m_valid", {63'd0, bus_if.m_valid}, 64'd0);
    check("rm_busy", {63'd0, busy}, 64'd0);
    check("rm_mem_re", {63'd0, bus_if.mem_re}, 64'd0);
    bus_if.m_ready = 1'b1;
    tick();

    // Address wrap and ignored start during LOAD
    exp_wr.push_back('{64'hFFFF_FFFF_FFFF_FFF8, 64'hA5});
    exp_wr.push_back('{64'h0, 64'h5A});
    exp_rd.push_back('{64'hA5, 1'b0});
    exp_rd.push_back('{64'h5A, 1'b1});
    begin_session(64'hFFFF_FFFF_FFFF_FFF8, 32'd2, 32'd2);
    begin_session(64'h100, 32'd7, 32'd9);
    check("ign_s_ready", {63'd0, bus_if.s_ready}, 64'd1);
    send_word(64'hA5);
    send_word(64'h5A);
    tick();
    check("wrap_run", {63'd0, cpu_rst}, 64'd0);
    halt();
    tick();
    check("wrap_rd_addr", bus_if.mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    wait_done();

    // Watchdog
    exp_rd.push_back('{64'd9, 1'b1});
    begin_session(64'h18, 32'd0, 32'd1);
`ifdef DMEM_HOST_PORT_WDOG_EN
    check("wd_t0", {63'd0, timeout}, 64'd0);
    repeat (99) tick();
    check("wd_t99", {63'd0, timeout}, 64'd0);
    check("wd_run99", {63'd0, cpu_rst}, 64'd0);
    tick();
    check("wd_t100", {63'd0, timeout}, 64'd1);
    check("wd_busy", {63'd0, busy}, 64'd1);
    wait_done();
    check("wd_sticky", {63'd0, timeout}, 64'd1);
    begin_session(64'h18, 32'd0, 32'd0);
    check("wd_clear", {63'd0, timeout}, 64'd0);
    halt();
    tick();
    check("wd_done2", {63'd0, done}, 64'd1);
`else
    repeat (150) tick();
    check("nowd_timeout", {63'd0, timeout}, 64'd0);
    check("nowd_run", {63'd0, cpu_rst}, 64'd0);
    halt();
    wait_done();
    check("nowd_timeout2", {63'd0, timeout}, 64'd0);
`endif

    tick();
    check("wr_q_empty", exp_wr.size(), 64'd0);
    check("rd_q_empty", exp_rd.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_host_port.md
# dmem_host_port

Host-side data-memory port for the LEGv8 pipeline system. Holds the CPU in reset while a host stream preloads data memory, releases the CPU, and detects the halt instruction (`B #0`) at WB. It then re-freezes the CPU and streams a data-memory region back out. It sits beside PipelineTOP and muxes onto the data-memory port.

## Interface
- `HALT_INST`, 32'h1400_0000, WB instruction that ends the run
- `TIMEOUT_CYCLES`, 32'd10_000_000, RUN-state watchdog limit (used only with the watchdog macro)
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse that begins a session; honoured only in IDLE/DONE
- `base_addr` in 64: byte address of word 0; must be 8-aligned
- `load_cnt` in 32: words to preload
- `dump_cnt` in 32: words to read back
- `s_valid`/`s_ready` in/out 1, `s_data` in 64: load stream
- `m_valid`/`m_ready` out/in 1, `m_data` out 64, `m_last` out 1: dump stream
- `mem_sel` out 1: 1 selects this block on the data-memory port, 0 selects the CPU
- `mem_we`, `mem_re` out 1: memory strobes
- `mem_addr` out 64: byte address
- `mem_wdata` out 64
- `mem_rdata` in 64: valid one cycle after `mem_re`
- `cpu_rst` out 1: active-high CPU reset
- `wb_inst` in 32: instruction in the WB stage
- `busy`, `done`, `timeout` out 1: status

## Operation
- States: IDLE → LOAD → RUN → HALT_WAIT → DUMP → DONE.
- IDLE
  - `cpu_rst`=1, `mem_sel`=1.
  - `start` latches `base_addr`, `load_cnt`, `dump_cnt` and clears the word index.
  - Goes to LOAD, or straight to RUN if `load_cnt`=0.
- LOAD
  - `s_ready`=1.
  - Each handshake writes `s_data` to `base + 8*i`, then increments i.
  - After handshake `load_cnt`: go to RUN.
- RUN
  - `cpu_rst`=0, `mem_sel`=0.
  - `wb_inst==HALT_INST` sampled at an edge: go to HALT_WAIT.
- HALT_WAIT
  - One settle cycle, with the CPU still running.
  - Then go to DUMP with `cpu_rst`=1, `mem_sel`=1, i=0.
- DUMP
  - Issue `mem_re` at `base + 8*i`.
  - The next cycle, capture `mem_rdata` into `m_data` and assert `m_valid`.
  - Hold `m_data` until `m_ready`; after the handshake, issue the next read.
  - `m_last`=1 on word `dump_cnt-1`.
  - `dump_cnt`=0: go directly to DONE.
- DONE
  - `done`=1, `cpu_rst`=1.
  - `start` begins a new session.
- Address arithmetic: 64-bit, `base + (i<<3)`, wraps modulo 2^64. Index counters are 32-bit.
- `busy`=1 in every state except IDLE and DONE.
- `start` outside IDLE/DONE is ignored. `s_valid` outside LOAD is ignored (`s_ready`=0).
- `rst` at any time: back to IDLE, all outputs at reset values, any in-flight stream word dropped.
- Reset values:
  - 1: `cpu_rst`, `mem_sel`.
  - 0: all other outputs.

## Timing
- `s_ready` is decoded from the state register.
- Load handshake at edge k: `mem_we`, `mem_addr`, `mem_wdata` are registered and valid for cycle k+1 only.
- After the final load handshake, the first RUN cycle (`cpu_rst`=0) follows the final write cycle.
- Halt seen at edge h:
  - HALT_WAIT during cycle h+1.
  - First `mem_re` in cycle h+2.
  - `m_valid` from cycle h+3.
- Dump throughput: one word per 2 cycles when `m_ready` is held high.
- `m_valid` never drops before its handshake. `m_data` and `m_last` are stable while `m_valid && !m_ready`.

## Configuration
- `DMEM_HOST_PORT_WDOG_EN` defined:
  - A 32-bit counter runs in RUN.
  - Reaching `TIMEOUT_CYCLES` sets `timeout`=1 and enters HALT_WAIT as if halted.
  - `timeout` stays set until the next `start` or `rst`.
- Macro undefined: no counter, `timeout` tied 0, RUN exits only on halt.

## Structure
- Shared package `legv8_host_pkg`:
  - state enum;
  - `HALT_INST_B0` constant (32'h1400_0000);
  - `WORD_BYTES`=8.
- Sub-module `dmem_rd_buf`: single-entry read capture/hold register driving `m_valid`/`m_data`/`m_last`.
- Top module: FSM, counters, address generation.

## Test plan
- **Preload then dump round trip.**
  - Stimulus: `base_addr`=0x18, `load_cnt`=4, words {9,2,0x45,1}.
  - Response: writes at 0x18,0x20,0x28,0x30; RUN starts the cycle after the last write.
  - After the halt is injected, with `dump_cnt`=4, the dump returns the memory model's contents, with `m_last` on word 3.
- **Zero counts.**
  - Stimulus: `load_cnt`=0, `dump_cnt`=0.
  - Response: IDLE → RUN directly; after halt, HALT_WAIT → DONE with no `m_valid`.
- **Back-pressure.**
  - Stimulus: `m_ready` low for 5 cycles during word 1.
  - Response: `m_data` and `m_last` stable, no extra `mem_re`.
- **Reset mid-DUMP.**
  - Stimulus: `rst` high for one cycle during DUMP.
  - Response: next cycle `cpu_rst`=1, `mem_sel`=1, `m_valid`=0, `busy`=0.
- **Watchdog (macro on, `TIMEOUT_CYCLES`=100, no halt).**
  - Response: `timeout`=1 after 100 RUN cycles, then the dump proceeds.
- **Address wrap and ignored `start`.**
  - Stimulus: `base_addr`=0xFFFF_FFFF_FFFF_FFF8, `load_cnt`=2.
  - Response: writes at 0xFFFF_FFFF_FFFF_FFF8 then 0x0.
  - A `start` pulse during LOAD is ignored.
